nibble_serial_add_ctrl: RTL and testbench

- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one external shared 4-bit carry-select adder, one nibble per cycle, LSB nibble first.
- Used in the CNN accumulation path where area matters more than latency.
- Operands are accepted and results returned over valid/ready handshakes.
- The adder itself is instantiated outside this block and connected through the add_* ports.

---
 rtl/nibble_serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract sequencer that time-shares one external 4-bit adder.
// Operands go in and results come out over valid/ready handshakes, LSB nibble first.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16,
  localparam int NIB = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] a_r, b_r, sum_r, sum_upd_s, sum_out_r;
  logic             sub_r, carry_r, cout_r, last_s;
  logic [IDXW-1:0]  idx_r;

  assign last_s    = (idx_r == IDXW'(NIB - 1));
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign sum       = sum_out_r;
  assign cout      = cout_r;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state decode and shared-adder operand steering (only live in RUN)
  always_comb begin
    state_nxt_s = state_r;
    add_a       = 4'b0000;
    add_b       = 4'b0000;
    add_cin     = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        add_a   = a_r[{idx_r, 2'b00} +: 4];
        add_b   = b_r[{idx_r, 2'b00} +: 4] ^ {4{sub_r}};
        add_cin = carry_r;
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // partial result with the current nibble merged in
  always_comb begin
    sum_upd_s = sum_r;
    sum_upd_s[{idx_r, 2'b00} +: 4] = add_sum;
  end

  // operand capture, nibble accumulation and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      sub_r     <= 1'b0;
      carry_r   <= 1'b0;
      idx_r     <= '0;
      sum_r     <= '0;
      sum_out_r <= '0;
      cout_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            sub_r   <= sub;
            carry_r <= sub;  // +1 of the two's complement enters as carry-in
            idx_r   <= '0;
          end
        end
        RUN: begin
          sum_r   <= sum_upd_s;
          carry_r <= add_cout;
          if (last_s) begin
            idx_r     <= '0;
            sum_out_r <= sum_upd_s;
            cout_r    <= add_cout;
          end else begin
            idx_r <= idx_r + IDXW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed and randomized checks of nibble_serial_add_ctrl at WIDTH 8, 16 and 32,
// each instance driving its own behavioural 4-bit adder.
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv[3], sb[3], ordy[3], ir[3], ov[3], co[3], ac[3], aco[3];
  logic [31:0] av[3], bv[3];
  logic [3:0]  aa[3], ab[3], as[3];
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [31:0] s32;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_adder
    assign {aco[g], as[g]} = {1'b0, aa[g]} + {1'b0, ab[g]} + {4'b0000, ac[g]};
  end

  nibble_serial_add_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0][7:0]), .b(bv[0][7:0]), .sub(sb[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .sum(s8), .cout(co[0]), .add_a(aa[0]), .add_b(ab[0]),
    .add_cin(ac[0]), .add_sum(as[0]), .add_cout(aco[0]));

  nibble_serial_add_ctrl #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1][15:0]), .b(bv[1][15:0]), .sub(sb[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .sum(s16), .cout(co[1]), .add_a(aa[1]), .add_b(ab[1]),
    .add_cin(ac[1]), .add_sum(as[1]), .add_cout(aco[1]));

  nibble_serial_add_ctrl #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(av[2]), .b(bv[2]), .sub(sb[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .sum(s32), .cout(co[2]), .add_a(aa[2]), .add_b(ab[2]),
    .add_cin(ac[2]), .add_sum(as[2]), .add_cout(aco[2]));

  function automatic int wid(input int k);
    return (k == 0) ? 8 : (k == 1) ? 16 : 32;
  endfunction

  // {cout, sum} of instance k
  function automatic logic [32:0] res(input int k);
    case (k)
      0:       return {24'd0, co[0], s8};
      1:       return {16'd0, co[1], s16};
      default: return {co[2], s32};
    endcase
  endfunction

  // reference: {cout,sum} = a + b or a + ~b + 1, in w+1 bits
  function automatic logic [32:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    logic [32:0] m, yy;
    m  = (33'd1 << w) - 33'd1;
    yy = s ? ~{1'b0, y} : {1'b0, y};
    return (({1'b0, x} & m) + (yy & m) + {32'd0, s}) & ((m << 1) | 33'd1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // one full transaction on instance k with `stall` cycles of out_ready=0 in DONE
  task automatic run_op(input int k, input logic [31:0] x, input logic [31:0] y, input logic s,
                        input int stall, input logic poke, output logic [32:0] r,
                        output logic [7:0] cins, output logic [3:0] b0);
    int n;
    logic [32:0] held;
    @(negedge clk);
    chk("idle_in_ready", 64'(ir[k]), 64'd1);
    iv[k] = 1'b1; av[k] = x; bv[k] = y; sb[k] = s;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    iv[k] = 1'b0;
    cins = 8'd0;
    b0 = ab[k];
    while (!ov[k] && n < 40) begin
      if (n <= 8) cins[n-1] = ac[k];
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", 64'(n), 64'(wid(k) / 4 + 1));
    chk("done_in_ready", 64'(ir[k]), 64'd0);
    held = res(k);
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        iv[k] = 1'b1; av[k] = 32'h1111; bv[k] = 32'h1111; sb[k] = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", 64'(ov[k]), 64'd1);
      chk("stall_result", 64'(res(k)), 64'(held));
      chk("stall_in_ready", 64'(ir[k]), 64'd0);
    end
    ordy[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[k] = 1'b0;
    iv[k] = 1'b0;
    chk("post_valid", 64'(ov[k]), 64'd0);
    chk("post_in_ready", 64'(ir[k]), 64'd1);
    r = held;
  endtask

  initial begin
    logic [32:0] r;
    logic [7:0]  cins;
    logic [3:0]  b0;
    logic [31:0] x, y;
    logic        s;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; sb[k] = 1'b0; ordy[k] = 1'b0; av[k] = 32'd0; bv[k] = 32'd0;
    end
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(ir[1]), 64'd1);
    chk("rst_out_valid", 64'(ov[1]), 64'd0);
    chk("rst_result", 64'(res(1)), 64'd0);
    chk("rst_add_bus", 64'({aa[1], ab[1], ac[1]}), 64'd0);
    rst_n = 1'b1;

    run_op(1, 32'h1234, 32'h4321, 1'b0, 0, 1'b0, r, cins, b0);
    chk("add_1234_4321", 64'(r), 64'h0_5555);
    chk("add_cin_zero", 64'(cins[3:0]), 64'h0);

    run_op(1, 32'hFFFF, 32'h0001, 1'b0, 1, 1'b0, r, cins, b0);
    chk("add_ffff_0001", 64'(r), 64'h1_0000);
    chk("ripple_cin_seq", 64'(cins[3:0]), 64'hE);

    run_op(1, 32'h0005, 32'h0007, 1'b1, 0, 1'b0, r, cins, b0);
    chk("sub_5_7", 64'(r), 64'h0_FFFE);
    run_op(1, 32'h0007, 32'h0005, 1'b1, 0, 1'b0, r, cins, b0);
    chk("sub_7_5", 64'(r), 64'h1_0002);
    chk("sub_first_add_b", 64'(b0), 64'hA);
    chk("sub_first_cin", 64'(cins[0]), 64'd1);

    run_op(1, 32'h1234, 32'h4321, 1'b0, 10, 1'b1, r, cins, b0);
    chk("backpressure", 64'(r), 64'h0_5555);
    run_op(1, 32'h0002, 32'h0003, 1'b0, 0, 1'b0, r, cins, b0);
    chk("after_poke", 64'(r), 64'h0_0005);

    run_op(0, 32'hFF, 32'h01, 1'b0, 2, 1'b0, r, cins, b0);
    chk("w8_wrap", 64'(r), 64'h100);
    run_op(2, 32'h1, 32'h2, 1'b1, 0, 1'b0, r, cins, b0);
    chk("w32_borrow", 64'(r), 64'h0_FFFF_FFFF);

    // reset during the second RUN cycle
    @(negedge clk);
    iv[1] = 1'b1; av[1] = 32'h1234; bv[1] = 32'h4321; sb[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(ir[1]), 64'd1);
    chk("abort_out_valid", 64'(ov[1]), 64'd0);
    chk("abort_result", 64'(res(1)), 64'd0);
    chk("abort_add_bus", 64'({aa[1], ab[1], ac[1]}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 32'h0001, 32'h0001, 1'b0, 0, 1'b0, r, cins, b0);
    chk("after_abort", 64'(r), 64'h0_0002);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < ((k == 1) ? 1000 : 300); i++) begin
        x = $urandom;
        y = $urandom;
        s = 1'($urandom_range(0, 1));
        run_op(k, x, y, s, $urandom_range(0, 3), 1'b0, r, cins, b0);
        chk("random", 64'(r), 64'(model(wid(k), x, y, s)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
